capture_trace_buffer: RTL and testbench
=======================================

Name: capture_trace_buffer

Overview:
- Parametrised on-chip capture buffer that records processor result words (`data` qualified by `enable`) during a programmable cycle window.
- Replaces file-dump style capture with synthesizable storage, drained over a valid/ready read port by a debug/UART reader or bench.
- Sits beside the processor top; generalises capture in data width, buffer depth, window length and full-buffer policy (stop vs wrap).

Parameters:
- DATA_W, 40: captured word width in bits.
- DEPTH, 16: buffer entries; power of 2, >= 2.
- WINDOW, 420: capture window length in cycles; 0 = unlimited (ends only on stop).
- WRAP_MODE, 0: 0 = drop new words when full; 1 = overwrite oldest when full.
- CNT_W, 16: width of drop counter and window counter.

Ports:
- clk  in  1  single clock, all logic posedge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  pulse: start or restart the capture window.
- stop  in  1  pulse: end the capture window early.
- clear  in  1  pulse: flush buffer, clear overflow and drop_cnt.
- cap_en  in  1  capture qualifier (processor enable).
- cap_data  in  DATA_W  word to capture.
- rd_valid  out  1  buffer non-empty.
- rd_ready  in  1  reader accepts word.
- rd_data  out  DATA_W  oldest word (first-word-fall-through).
- level  out  $clog2(DEPTH)+1  entries held.
- busy  out  1  state == CAPTURE.
- done  out  1  state == DONE.
- overflow  out  1  sticky: at least one word dropped or overwritten.
- drop_cnt  out  CNT_W  dropped/overwritten words, saturating at all-ones.

Behaviour:
- Reset (rst=1 at posedge): state IDLE; pointers and level 0; rd_valid=0; rd_data undefined but stable; busy=0; done=0; overflow=0; drop_cnt=0; window counter 0. Reset wins over every other input.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE/DONE + arm -> CAPTURE; window counter := WINDOW.
  - CAPTURE + arm -> stays CAPTURE; counter reloads; buffer contents kept.
  - CAPTURE + stop -> DONE.
  - CAPTURE with WINDOW != 0: counter decrements every cycle; the cycle the counter equals 1 is the last capture cycle; next state is DONE. Exactly WINDOW capture cycles per arm.
  - arm and stop in the same cycle: arm wins.
  - DONE holds until arm; clear does not change state.
- Write: occurs when state == CAPTURE and cap_en=1. The word becomes visible on rd_valid/rd_data the next cycle (1-cycle latency).
- Read: pop when rd_valid && rd_ready. rd_data is combinational from storage at the read pointer. Pop when empty is ignored.
- Pointers: log2(DEPTH) bits, natural wrap-around. level = writes - pops.
- Full, WRAP_MODE=0:
  - push without pop: word dropped; overflow=1; drop_cnt++.
  - push with pop in the same cycle: both occur; level unchanged; no drop.
- Full, WRAP_MODE=1:
  - push without pop: oldest overwritten; read pointer advances; level stays DEPTH; overflow=1; drop_cnt++.
  - push with pop: normal push+pop; no drop.
- Empty, push and pop in the same cycle: pop ignored; push accepted; level becomes 1.
- clear: pointers and level := 0; overflow := 0; drop_cnt := 0. A push in the same cycle is discarded and not counted. clear has priority over push and pop.
- drop_cnt saturates at 2^CNT_W-1; it never wraps.

Optional Feature:
- Macro CAPTURE_TSTAMP_EN.
- Defined:
  - A free-running CNT_W-bit cycle counter, cleared by rst, starts at 0 and wraps.
  - The counter value is stored alongside each captured word.
  - Extra output rd_tstamp (out, CNT_W) shows the cycle the head word was written, aligned with rd_data.
- Undefined: no counter, no rd_tstamp port, storage DATA_W bits wide.

Test Plan:
- Reset, then arm; cap_en=1 for 5 cycles with data 1..5; rd_ready=0 -> level=5, rd_data=1; after 5 pops data reads 1,2,3,4,5, then rd_valid=0.
- WINDOW=8, cap_en held 1, rd_ready=0, DEPTH=16 -> exactly 8 words captured; busy drops and done=1 on the cycle after the 8th capture; further cap_en is ignored.
- WRAP_MODE=0, DEPTH=4, 6 pushes of 10..15, no reads -> contents 10..13; overflow=1; drop_cnt=2.
- WRAP_MODE=1, same stimulus -> reads 12,13,14,15; overflow=1; drop_cnt=2.
- Full buffer with simultaneous push and pop (mode 0) -> level stays 4; no drop. Then clear with concurrent push -> level=0, overflow=0, drop_cnt=0.
- rst asserted mid-capture with level=3 -> next cycle IDLE, level=0, busy=0, all flags 0.
- With CAPTURE_TSTAMP_EN: reset, arm at cycle 2, push at cycles 3 and 7 -> rd_tstamp reads 3, then 7.

Source files
------------

// File: rtl/capture_trace_buffer.sv
// Windowed capture buffer for processor result words, drained over a valid/ready port.
// Optional feature: define CAPTURE_TSTAMP_EN to store a cycle timestamp with each word.
module capture_trace_buffer #(
    parameter int unsigned DATA_W    = 40,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WINDOW    = 420,
    parameter int unsigned WRAP_MODE = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     clear,
    input  logic                     cap_en,
    input  logic [DATA_W-1:0]        cap_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_W-1:0]        rd_data,
`ifdef CAPTURE_TSTAMP_EN
    output logic [CNT_W-1:0]         rd_tstamp,
`endif
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned LvlW = AW + 1;
`ifdef CAPTURE_TSTAMP_EN
    localparam int unsigned MemW = DATA_W + CNT_W;
`else
    localparam int unsigned MemW = DATA_W;
`endif

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCapture = 2'd1;
    localparam logic [1:0] StDone    = 2'd2;

    localparam logic [AW:0]      FullLvl = DEPTH[AW:0];
    localparam logic [CNT_W-1:0] WinLoad = WINDOW[CNT_W-1:0];

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [MemW-1:0]  mem [DEPTH];
    logic [MemW-1:0]  wdata;
    logic             we;
    logic             push, pop, full;

`ifdef CAPTURE_TSTAMP_EN
    logic [CNT_W-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + 1'b1;
    end

    assign wdata     = {ts_q, cap_data};
    assign rd_tstamp = mem[rd_ptr_q][MemW-1:DATA_W];
`else
    assign wdata     = cap_data;
`endif

    // Window counter holds the number of capture cycles still to come, including this one.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        if (arm) begin
            state_d = StCapture;
            win_d   = WinLoad;
        end else if (state_q == StCapture) begin
            if (stop) begin
                state_d = StDone;
            end else if (WINDOW != 0) begin
                if (win_q == CNT_W'(1)) state_d = StDone;
                win_d = win_q - 1'b1;
            end
        end
    end

    assign push = (state_q == StCapture) && cap_en;
    assign pop  = rd_valid && rd_ready;
    assign full = (level_q == FullLvl);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        we       = 1'b0;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            drop_d   = '0;
        end else if (push && full && !pop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + 1'b1;
            // Wrap mode overwrites the oldest slot, which the write pointer already addresses.
            if (WRAP_MODE != 0) begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end else begin
            if (push) begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + LvlW'(push) - LvlW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            win_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && we) mem[wr_ptr_q] <= wdata;
    end

    assign rd_valid = (level_q != '0);
    assign rd_data  = mem[rd_ptr_q][DATA_W-1:0];
    assign level    = level_q;
    assign busy     = (state_q == StCapture);
    assign done     = (state_q == StDone);
    assign overflow = ovf_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_capture_trace_buffer.sv
// Bench for capture_trace_buffer: three configurations driven in lockstep against a queue model.
module tb_capture_trace_buffer;

    localparam int unsigned DW  = 16;
    localparam int unsigned CW  = 4;
    localparam int unsigned WIN = 8;
    localparam int unsigned NI  = 3;
    localparam int unsigned DEP [NI] = '{4, 4, 16};
    localparam int unsigned WRP [NI] = '{0, 1, 0};
    localparam int          SAT = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, arm, stop, clear, cap_en, rd_ready;
    logic [DW-1:0] cap_data;

    logic          rd_valid [NI];
    logic [DW-1:0] rd_data  [NI];
    logic [4:0]    level    [NI];
    logic          busy     [NI];
    logic          done     [NI];
    logic          ovf      [NI];
    logic [CW-1:0] drop     [NI];
`ifdef CAPTURE_TSTAMP_EN
    logic [CW-1:0] ts       [NI];
`endif

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [$clog2(DEP[g]):0] lvl;
        capture_trace_buffer #(
            .DATA_W    (DW),
            .DEPTH     (DEP[g]),
            .WINDOW    (WIN),
            .WRAP_MODE (WRP[g]),
            .CNT_W     (CW)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .arm       (arm),
            .stop      (stop),
            .clear     (clear),
            .cap_en    (cap_en),
            .cap_data  (cap_data),
            .rd_valid  (rd_valid[g]),
            .rd_ready  (rd_ready),
            .rd_data   (rd_data[g]),
`ifdef CAPTURE_TSTAMP_EN
            .rd_tstamp (ts[g]),
`endif
            .level     (lvl),
            .busy      (busy[g]),
            .done      (done[g]),
            .overflow  (ovf[g]),
            .drop_cnt  (drop[g])
        );
        assign level[g] = 5'(lvl);
    end

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] t;
    } ent_t;

    ent_t mq [NI][$];
    bit   m_ovf  [NI];
    int   m_drop [NI];
    int   m_state;  // 0 idle, 1 capture, 2 done
    int   m_win;
    int   m_ts;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit   push, pop;
        ent_t e;
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                mq[i].delete();
                m_ovf[i]  = 1'b0;
                m_drop[i] = 0;
            end
            m_state = 0;
            m_win   = 0;
            m_ts    = 0;
            return;
        end
        push = (m_state == 1) && cap_en;
        e.d  = cap_data;
        e.t  = CW'(m_ts);
        for (int i = 0; i < NI; i++) begin
            pop = (mq[i].size() != 0) && rd_ready;
            if (clear) begin
                mq[i].delete();
                m_ovf[i]  = 1'b0;
                m_drop[i] = 0;
            end else begin
                if (pop) void'(mq[i].pop_front());
                if (push) begin
                    if (mq[i].size() < int'(DEP[i])) begin
                        mq[i].push_back(e);
                    end else begin
                        m_ovf[i] = 1'b1;
                        if (m_drop[i] < SAT) m_drop[i]++;
                        if (WRP[i] != 0) begin
                            void'(mq[i].pop_front());
                            mq[i].push_back(e);
                        end
                    end
                end
            end
        end
        if (arm) begin
            m_state = 1;
            m_win   = WIN;
        end else if (m_state == 1) begin
            if (stop) m_state = 2;
            else if (WIN != 0) begin
                if (m_win == 1) m_state = 2;
                m_win--;
            end
        end
        m_ts = (m_ts + 1) % (1 << CW);
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("u%0d.rd_valid", i), 32'(rd_valid[i]), 32'(mq[i].size() != 0));
            check_val($sformatf("u%0d.level", i), 32'(level[i]), 32'(mq[i].size()));
            check_val($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(m_state == 1));
            check_val($sformatf("u%0d.done", i), 32'(done[i]), 32'(m_state == 2));
            check_val($sformatf("u%0d.overflow", i), 32'(ovf[i]), 32'(m_ovf[i]));
            check_val($sformatf("u%0d.drop_cnt", i), 32'(drop[i]), 32'(m_drop[i]));
            if (mq[i].size() != 0) begin
                check_val($sformatf("u%0d.rd_data", i), 32'(rd_data[i]), 32'(mq[i][0].d));
`ifdef CAPTURE_TSTAMP_EN
                check_val($sformatf("u%0d.rd_tstamp", i), 32'(ts[i]), 32'(mq[i][0].t));
`endif
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; stop = 1'b0; clear = 1'b0;
        cap_en = 1'b0; rd_ready = 1'b0; cap_data = '0;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst.level", 32'(level[2]), 0);
        check_val("rst.valid", 32'(rd_valid[2]), 0);
        check_val("rst.busy", 32'(busy[2]), 0);

        // Five words into the deep buffer, then drain in order.
        arm = 1'b1; tick(); arm = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cap_en = 1'b1; cap_data = DW'(k); tick();
        end
        cap_en = 1'b0;
        check_val("A.level", 32'(level[2]), 5);
        check_val("A.head", 32'(rd_data[2]), 1);
        rd_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            check_val("A.pop", 32'(rd_data[2]), 32'(k));
            tick();
        end
        rd_ready = 1'b0;
        check_val("A.empty", 32'(rd_valid[2]), 0);

        // Window of 8 capture cycles.
        pulse_clear();
        arm = 1'b1; tick(); arm = 1'b0;
        cap_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cap_data = DW'(100 + k);
            tick();
            check_val("B.busy", 32'(busy[2]), 32'(k < 8));
            check_val("B.done", 32'(done[2]), 32'(k >= 8));
        end
        cap_en = 1'b0;
        check_val("B.level", 32'(level[2]), 8);

        // Six pushes into depth 4: drop vs wrap.
        pulse_clear();
        arm = 1'b1; tick(); arm = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cap_en = 1'b1; cap_data = DW'(10 + k); tick();
        end
        cap_en = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        check_val("C0.level", 32'(level[0]), 4);
        check_val("C0.overflow", 32'(ovf[0]), 1);
        check_val("C0.drop", 32'(drop[0]), 2);
        check_val("C1.overflow", 32'(ovf[1]), 1);
        check_val("C1.drop", 32'(drop[1]), 2);
        rd_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check_val("C0.rd", 32'(rd_data[0]), 32'(10 + j));
            check_val("C1.rd", 32'(rd_data[1]), 32'(12 + j));
            tick();
        end
        rd_ready = 1'b0;

        // Full with simultaneous push/pop, then clear with a concurrent push.
        pulse_clear();
        arm = 1'b1; tick(); arm = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cap_en = 1'b1; cap_data = DW'(20 + k); tick();
        end
        cap_data = DW'(24); rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        check_val("D.level", 32'(level[0]), 4);
        check_val("D.drop", 32'(drop[0]), 0);
        clear = 1'b1; cap_data = DW'(25); tick(); clear = 1'b0; cap_en = 1'b0;
        check_val("D.clr_level", 32'(level[0]), 0);
        check_val("D.clr_ovf", 32'(ovf[0]), 0);
        check_val("D.clr_drop", 32'(drop[0]), 0);

        // Reset in the middle of a capture.
        arm = 1'b1; tick(); arm = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cap_en = 1'b1; cap_data = DW'(30 + k); tick();
        end
        cap_en = 1'b0;
        check_val("E.pre_level", 32'(level[2]), 3);
        rst = 1'b1; tick(); rst = 1'b0;
        check_val("E.level", 32'(level[2]), 0);
        check_val("E.busy", 32'(busy[2]), 0);
        check_val("E.done", 32'(done[2]), 0);
        check_val("E.valid", 32'(rd_valid[2]), 0);
        check_val("E.ovf", 32'(ovf[2]), 0);

`ifdef CAPTURE_TSTAMP_EN
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); tick();
        arm = 1'b1; tick(); arm = 1'b0;
        cap_en = 1'b1; cap_data = DW'(16'h55); tick(); cap_en = 1'b0;
        tick(); tick(); tick();
        cap_en = 1'b1; cap_data = DW'(16'h66); tick(); cap_en = 1'b0;
        check_val("F.ts0", 32'(ts[2]), 3);
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
        check_val("F.ts1", 32'(ts[2]), 7);
`endif

        // Drop counter saturation: keep re-arming with no reads.
        pulse_clear();
        cap_en = 1'b1; arm = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cap_data = DW'($urandom);
            tick();
        end
        arm = 1'b0; cap_en = 1'b0;
        check_val("G.sat", 32'(drop[0]), 32'(SAT));
        check_val("G.sat_wrap", 32'(drop[1]), 32'(SAT));

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            arm      = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            clear    = ($urandom_range(0, 31) == 0);
            cap_en   = ($urandom_range(0, 3) != 0);
            rd_ready = ($urandom_range(0, 2) == 0);
            cap_data = DW'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
